// File: rtl/acc_drain_if.sv
// Output stream of the accumulator drain: one narrowed element per valid/ready transfer.
interface acc_drain_if #(
  parameter int OW = 16,
  parameter int IW = 2
);
  logic          out_valid;
  logic          out_ready;
  logic [OW-1:0] out_data;
  logic [IW-1:0] out_idx;
  logic          out_last;

  modport master (output out_valid, out_data, out_idx, out_last, input out_ready);
  modport slave  (input out_valid, out_data, out_idx, out_last, output out_ready);
endinterface

// File: rtl/acc_drain.sv
// Snapshots N accumulator sums, pulses clr_acc, then streams the row out narrowed to OW bits.
// Optional saturation with sticky ovf flag is enabled by defining ACC_DRAIN_SAT_EN.
module acc_drain #(
  parameter int DW = 8,
  parameter int RW = 3*DW,
  parameter int N  = 4,
  parameter int OW = 2*DW,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [N*RW-1:0] sums_in,
  output logic          clr_acc,
  output logic          busy,
  output logic          ovf,
  acc_drain_if.master   out
);

  typedef enum logic {IDLE, SEND} state_t;

  state_t        state;
  logic [RW-1:0] sbuf [N];
  logic [IW-1:0] idx;
  logic          last;
  logic          valid;
  logic [RW-1:0] cur;

  assign valid         = (state == SEND);
  assign busy          = valid;
  assign out.out_valid = valid;
  assign out.out_idx   = idx;
  assign out.out_last  = last;
  assign cur           = sbuf[idx];

  // Loads are only honoured in IDLE, so a reload during the final transfer is dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      idx     <= '0;
      last    <= 1'b0;
      clr_acc <= 1'b0;
      for (int i = 0; i < N; i++) sbuf[i] <= '0;
    end else begin
      clr_acc <= 1'b0;
      case (state)
        IDLE: begin
          if (load) begin
            for (int i = 0; i < N; i++) sbuf[i] <= sums_in[i*RW +: RW];
            idx     <= '0;
            last    <= (N == 1);
            clr_acc <= 1'b1;
            state   <= SEND;
          end
        end
        SEND: begin
          if (out.out_ready) begin
            if (idx == IW'(N-1)) begin
              state <= IDLE;
              idx   <= '0;
              last  <= 1'b0;
            end else begin
              idx  <= idx + 1'b1;
              last <= ((idx + 1'b1) == IW'(N-1));
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ACC_DRAIN_SAT_EN
  logic sat_hit;

  if (OW >= RW) begin : g_ext
    assign sat_hit      = 1'b0;
    assign out.out_data = OW'(cur);
  end else begin : g_sat
    assign sat_hit      = |cur[RW-1:OW];
    assign out.out_data = sat_hit ? {OW{1'b1}} : cur[OW-1:0];
  end

  // Sticky until the next accepted load; set when a clipped element actually leaves.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf <= 1'b0;
    end else if (state == IDLE && load) begin
      ovf <= 1'b0;
    end else if (state == SEND && out.out_ready && sat_hit) begin
      ovf <= 1'b1;
    end
  end
`else
  assign ovf = 1'b0;

  if (OW >= RW) begin : g_ext
    assign out.out_data = OW'(cur);
  end else begin : g_trunc
    logic unused_hi;
    assign unused_hi    = ^cur[RW-1:OW];
    assign out.out_data = cur[OW-1:0];
  end
`endif

endmodule

// File: tb/tb_acc_drain.sv
// Directed self-checking bench for acc_drain (DW=8, RW=24, N=4, OW=16).
module tb_acc_drain;

  localparam int RW = 24;
  localparam int N  = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          load;
  logic [N*RW-1:0] sums;
  logic          clr_acc;
  logic          busy;
  logic          ovf;
  int            total = 0;
  int            bad   = 0;

  acc_drain_if #(.OW(16), .IW(2)) sif ();

  acc_drain #(.DW(8), .RW(RW), .N(N), .OW(16), .IW(2)) dut (
    .clk     (clk),
    .rst     (rst),
    .load    (load),
    .sums_in (sums),
    .clr_acc (clr_acc),
    .busy    (busy),
    .ovf     (ovf),
    .out     (sif)
  );

  always #5 clk = ~clk;

  wire [21:0] obs  = {sif.out_valid, busy, clr_acc, sif.out_last, sif.out_idx, sif.out_data};
  wire [5:0]  ctrl = obs[21:16];

  function automatic logic [21:0] pack(input logic v, input logic b, input logic c,
                                       input logic l, input logic [1:0] i, input logic [15:0] d);
    return {v, b, c, l, i, d};
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  // Issues a one-cycle load at the current negedge; returns at the first valid cycle.
  task automatic do_load(input logic [N*RW-1:0] s);
    sums = s;
    load = 1'b1;
    tick();
    load = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; load = 1'b0; sums = '0; sif.out_ready = 1'b0;
    #3;
    total++;
    if (obs !== 22'd0 || ovf !== 1'b0) begin
      bad++; $display("[TB] FAIL reset got=%h ovf=%b want=0", obs, ovf);
    end
    tick();
    rst = 1'b0;
    tick();
    total++;
    if (obs !== 22'd0) begin
      bad++; $display("[TB] FAIL reset_idle got=%h want=0", obs);
    end
  endtask

  task automatic test_basic();
    logic [15:0] exp_d [4] = '{16'h0010, 16'h0020, 16'h0030, 16'h0040};
    sif.out_ready = 1'b1;
    do_load({24'h000040, 24'h000030, 24'h000020, 24'h000010});
    for (int i = 0; i < 4; i++) begin
      total++;
      if (obs !== pack(1'b1, 1'b1, i == 0, i == 3, 2'(i), exp_d[i])) begin
        bad++; $display("[TB] FAIL basic[%0d] got=%h want=%h", i, obs,
                        pack(1'b1, 1'b1, i == 0, i == 3, 2'(i), exp_d[i]));
      end
      tick();
    end
    total++;
    if (ctrl !== 6'd0) begin
      bad++; $display("[TB] FAIL basic_end got=%b want=000000", ctrl);
    end
  endtask

  task automatic test_backpressure();
    logic       rdy   [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    logic [1:0] exp_i [7] = '{2'd0, 2'd1, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3};
    logic [15:0] exp_d;
    sif.out_ready = 1'b0;
    do_load({24'h000040, 24'h000030, 24'h000020, 24'h000010});
    for (int i = 0; i < 7; i++) begin
      sif.out_ready = rdy[i];
      exp_d = 16'h0010 * (16'(exp_i[i]) + 16'd1);
      total++;
      if (obs !== pack(1'b1, 1'b1, i == 0, exp_i[i] == 2'd3, exp_i[i], exp_d)) begin
        bad++; $display("[TB] FAIL bp[%0d] got=%h want=%h", i, obs,
                        pack(1'b1, 1'b1, i == 0, exp_i[i] == 2'd3, exp_i[i], exp_d));
      end
      tick();
    end
    total++;
    if (ctrl !== 6'd0) begin
      bad++; $display("[TB] FAIL bp_end got=%b want=000000", ctrl);
    end
  endtask

  task automatic test_load_busy();
    logic [15:0] exp_n [4] = '{16'h0011, 16'h0022, 16'h0033, 16'h0044};
    sif.out_ready = 1'b1;
    do_load({24'h000040, 24'h000030, 24'h000020, 24'h000010});
    tick();
    total++;
    if (obs !== pack(1'b1, 1'b1, 1'b0, 1'b0, 2'd1, 16'h0020)) begin
      bad++; $display("[TB] FAIL busy_c1 got=%h want=%h", obs, pack(1'b1, 1'b1, 1'b0, 1'b0, 2'd1, 16'h0020));
    end
    sums = {4{24'hAAAAAA}};
    load = 1'b1;
    tick();
    load = 1'b0;
    total++;
    if (obs !== pack(1'b1, 1'b1, 1'b0, 1'b0, 2'd2, 16'h0030)) begin
      bad++; $display("[TB] FAIL busy_ignored got=%h want=%h", obs, pack(1'b1, 1'b1, 1'b0, 1'b0, 2'd2, 16'h0030));
    end
    tick();
    total++;
    if (obs !== pack(1'b1, 1'b1, 1'b0, 1'b1, 2'd3, 16'h0040)) begin
      bad++; $display("[TB] FAIL busy_last got=%h want=%h", obs, pack(1'b1, 1'b1, 1'b0, 1'b1, 2'd3, 16'h0040));
    end
    load = 1'b1;
    tick();
    load = 1'b0;
    total++;
    if (ctrl !== 6'd0) begin
      bad++; $display("[TB] FAIL busy_final_load got=%b want=000000", ctrl);
    end
    do_load({24'h000044, 24'h000033, 24'h000022, 24'h000011});
    for (int i = 0; i < 4; i++) begin
      total++;
      if (obs !== pack(1'b1, 1'b1, i == 0, i == 3, 2'(i), exp_n[i])) begin
        bad++; $display("[TB] FAIL reload[%0d] got=%h want=%h", i, obs,
                        pack(1'b1, 1'b1, i == 0, i == 3, 2'(i), exp_n[i]));
      end
      tick();
    end
    total++;
    if (ctrl !== 6'd0) begin
      bad++; $display("[TB] FAIL reload_end got=%b want=000000", ctrl);
    end
  endtask

  task automatic test_narrowing();
`ifdef ACC_DRAIN_SAT_EN
    logic [15:0] exp_d [4] = '{16'hFFFF, 16'hFFFF, 16'h0001, 16'hFFFF};
    logic        exp_o [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
    logic        exp_end   = 1'b1;
`else
    logic [15:0] exp_d [4] = '{16'h2345, 16'hFFFF, 16'h0001, 16'hFFFF};
    logic        exp_o [4] = '{1'b0, 1'b0, 1'b0, 1'b0};
    logic        exp_end   = 1'b0;
`endif
    sif.out_ready = 1'b1;
    do_load({24'hFFFFFF, 24'h000001, 24'h00FFFF, 24'h012345});
    for (int i = 0; i < 4; i++) begin
      total++;
      if (obs !== pack(1'b1, 1'b1, i == 0, i == 3, 2'(i), exp_d[i]) || ovf !== exp_o[i]) begin
        bad++; $display("[TB] FAIL narrow[%0d] got=%h ovf=%b want=%h ovf=%b", i, obs, ovf,
                        pack(1'b1, 1'b1, i == 0, i == 3, 2'(i), exp_d[i]), exp_o[i]);
      end
      tick();
    end
    total++;
    if (ovf !== exp_end || ctrl !== 6'd0) begin
      bad++; $display("[TB] FAIL narrow_sticky got ovf=%b ctrl=%b want ovf=%b ctrl=000000", ovf, ctrl, exp_end);
    end
    do_load({24'h000040, 24'h000030, 24'h000020, 24'h000010});
    total++;
    if (ovf !== 1'b0 || obs !== pack(1'b1, 1'b1, 1'b1, 1'b0, 2'd0, 16'h0010)) begin
      bad++; $display("[TB] FAIL ovf_clear got ovf=%b obs=%h want ovf=0 obs=%h", ovf, obs,
                      pack(1'b1, 1'b1, 1'b1, 1'b0, 2'd0, 16'h0010));
    end
    repeat (4) tick();
  endtask

  task automatic test_reset_midstream();
    logic [15:0] exp_d [4] = '{16'h0055, 16'h0066, 16'h0077, 16'h0088};
    sif.out_ready = 1'b1;
    do_load({24'h000040, 24'h000030, 24'h000020, 24'h000010});
    tick();
    tick();
    total++;
    if (obs !== pack(1'b1, 1'b1, 1'b0, 1'b0, 2'd2, 16'h0030)) begin
      bad++; $display("[TB] FAIL rst_pre got=%h want=%h", obs, pack(1'b1, 1'b1, 1'b0, 1'b0, 2'd2, 16'h0030));
    end
    #2 rst = 1'b1;
    #1;
    total++;
    if (obs !== 22'd0) begin
      bad++; $display("[TB] FAIL rst_async got=%h want=0", obs);
    end
    tick();
    rst = 1'b0;
    tick();
    total++;
    if (obs !== 22'd0) begin
      bad++; $display("[TB] FAIL rst_release got=%h want=0", obs);
    end
    // Abort during the clr_acc cycle must drop the pulse immediately too.
    do_load({24'h000088, 24'h000077, 24'h000066, 24'h000055});
    #1 rst = 1'b1;
    #1;
    total++;
    if (clr_acc !== 1'b0 || obs !== 22'd0) begin
      bad++; $display("[TB] FAIL rst_clr got clr=%b obs=%h want clr=0 obs=0", clr_acc, obs);
    end
    tick();
    rst = 1'b0;
    do_load({24'h000088, 24'h000077, 24'h000066, 24'h000055});
    for (int i = 0; i < 4; i++) begin
      total++;
      if (obs !== pack(1'b1, 1'b1, i == 0, i == 3, 2'(i), exp_d[i])) begin
        bad++; $display("[TB] FAIL rst_restream[%0d] got=%h want=%h", i, obs,
                        pack(1'b1, 1'b1, i == 0, i == 3, 2'(i), exp_d[i]));
      end
      tick();
    end
    total++;
    if (ctrl !== 6'd0) begin
      bad++; $display("[TB] FAIL rst_end got=%b want=000000", ctrl);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_load_busy();
    test_narrowing();
    test_reset_midstream();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog got=timeout want=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
